// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// the width rule for the phase timer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_RDY   = 3'd1,
    ST_STEP       = 3'd2,
    ST_DONE       = 3'd3,
    ST_REV_ASSERT = 3'd4
  } seq_state_t;

  // One spare bit above the largest terminal count so the timer can never wrap.
  function automatic int cnt_width(input int hold, input int step, input int timeout);
    int m;
    m = hold;
    if (step > m) m = step;
    if (timeout > m) m = timeout;
    return $clog2(m + 1) + 1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with clear, enable and terminal-count compare; shared by
// the hold, step-gap and ready-timeout phases of the reset sequencer.
module seq_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clear)     count <= '0;
    else if (load) count <= load_value;
    else if (en)   count <= count + WIDTH'(1);
  end

  // tc flags that the coming enabled edge is the terminal-th edge of the phase.
  assign tc = (count == terminal - WIDTH'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_DOMAINS active-low domain resets, gated by per-domain
// ready or timeout. Optional macro RESET_SEQ_REVERSE_EN: staged reverse re-assert.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           sw_reset,
  input  logic [NUM_DOMAINS-1:0]         rdy,
  output logic [NUM_DOMAINS-1:0]         domain_rst_n,
  output logic [$clog2(NUM_DOMAINS)-1:0] cur_domain,
  output logic                           seq_done,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_DOMAINS);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES, TIMEOUT_CYCLES);

  seq_state_t       state;
  logic             tc;
  logic             tmr_clear;
  logic             tmr_en;
  logic [CNT_W-1:0] terminal;
  logic             rdy_cur;
  logic             timeout_hit;
  logic             resequence;

  assign rdy_cur     = rdy[cur_domain];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT_RDY) && tc;
  assign resequence  = sw_reset && (state != ST_HOLD) && (state != ST_REV_ASSERT);

  // The timer restarts from zero on every phase change so each phase counts its own edges.
  always_comb begin
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    terminal  = CNT_W'(STEP_CYCLES);
    case (state)
      ST_HOLD: begin
        terminal  = CNT_W'(HOLD_CYCLES);
        tmr_clear = sw_reset || tc;
        tmr_en    = 1'b1;
      end
      ST_WAIT_RDY: begin
        terminal  = CNT_W'(TIMEOUT_CYCLES);
        tmr_clear = rdy_cur || timeout_hit;
        tmr_en    = (TIMEOUT_CYCLES != 0);
      end
      ST_STEP, ST_REV_ASSERT: begin
        tmr_clear = tc;
        tmr_en    = 1'b1;
      end
      default: tmr_clear = 1'b1;
    endcase
    if (!areset || resequence) tmr_clear = 1'b1;
  end

  seq_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .clear      (tmr_clear),
    .load       (1'b0),
    .load_value ('0),
    .en         (tmr_en),
    .terminal   (terminal),
    .tc         (tc)
  );

  always_ff @(posedge clk) begin
    if (!areset) begin
      state        <= ST_HOLD;
      domain_rst_n <= '0;
      cur_domain   <= '0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (resequence) begin
`ifdef RESET_SEQ_REVERSE_EN
      // cur_domain is always the highest released domain outside HOLD.
      domain_rst_n[cur_domain] <= 1'b0;
      seq_done                 <= 1'b0;
      if (cur_domain == '0) state <= ST_HOLD;
      else                  state <= ST_REV_ASSERT;
`else
      state        <= ST_HOLD;
      domain_rst_n <= '0;
      cur_domain   <= '0;
      seq_done     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_HOLD: begin
          if (!sw_reset && tc) begin
            domain_rst_n[0] <= 1'b1;
            state           <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          // A ready seen on the timeout edge wins and leaves the error flag alone.
          if (rdy_cur || timeout_hit) begin
            if (!rdy_cur) timeout_err <= 1'b1;
            if (cur_domain == IDX_W'(NUM_DOMAINS - 1)) begin
              state    <= ST_DONE;
              seq_done <= 1'b1;
            end else begin
              state <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          if (tc) begin
            cur_domain                              <= cur_domain + IDX_W'(1);
            domain_rst_n[cur_domain + IDX_W'(1)]    <= 1'b1;
            state                                   <= ST_WAIT_RDY;
          end
        end
        ST_DONE: ;
`ifdef RESET_SEQ_REVERSE_EN
        ST_REV_ASSERT: begin
          if (tc) begin
            domain_rst_n[cur_domain - IDX_W'(1)] <= 1'b0;
            cur_domain                           <= cur_domain - IDX_W'(1);
            if (cur_domain == IDX_W'(1)) state <= ST_HOLD;
          end
        end
`endif
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
